// File: rtl/seq_shift_multiplier.sv
// seq_shift_multiplier: iterative shift-add WIDTH x WIDTH multiplier.
// One partial-product bit is retired per clock. Operand and result sides
// use valid/ready handshakes. Signed operands are multiplied as magnitudes
// and the sign is applied to the finished product.
// Optional build macro SEQ_MUL_EARLY_TERM_EN: finish as soon as the
// remaining multiplier bits are all zero. Without it, BUSY always lasts
// WIDTH cycles.
module seq_shift_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier_shift;
    logic                 last_iter;

    // |v| for two's-complement input; the most negative value maps onto
    // itself, which is the correct unsigned magnitude 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v[WIDTH-1])
            return ~v + WIDTH'(1);
        return v;
    endfunction

    // Restore the product sign; magnitudes never overflow 2*WIDTH bits.
    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                      input logic negate);
        if (negate)
            return ~v + (2*WIDTH)'(1);
        return v;
    endfunction

    assign acc_sum      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mplier_shift = mplier_q >> 1;

`ifdef SEQ_MUL_EARLY_TERM_EN
    assign last_iter = (count_q == LAST_CNT) || (mplier_shift == '0);
`else
    assign last_iter = (count_q == LAST_CNT);
`endif

    // State register: reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic: accept in IDLE, iterate in BUSY, hold DONE until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next-state: operand capture, shift-add step, final sign fix.
    always_comb begin
        count_d   = count_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
                    mplier_d = magnitude(b, signed_mode);
                    acc_d    = '0;
                    count_d  = '0;
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                end
            end
            BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                count_d  = count_q + CNT_W'(1);
                if (last_iter)
                    product_d = apply_sign(acc_sum, neg_q);
            end
            default: ;
        endcase
    end

    // Datapath registers; product holds its value after the result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            count_q   <= count_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_shift_multiplier.sv
// Self-checking bench for seq_shift_multiplier (WIDTH=32).
// Expected products are pushed to a scoreboard queue at operand acceptance
// and popped when the DUT presents a result.
module tb_seq_shift_multiplier;

    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   product;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*W-1:0] exp_q[$];

    seq_shift_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product)
    );

    always #5 clk = ~clk;

    // Reference product: extend to 2W bits and multiply modulo 2^(2W).
    function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] x,
                                                 input logic [W-1:0] y,
                                                 input logic sm);
        logic [2*W-1:0] ex;
        logic [2*W-1:0] ey;
        ex = sm ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ey = sm ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return ex * ey;
    endfunction

    // Expected cycles from accepting edge to out_valid.
    function automatic int exp_lat(input logic [W-1:0] y, input logic sm);
`ifdef SEQ_MUL_EARLY_TERM_EN
        logic [W-1:0] m;
        int hi;
        m  = (sm && y[W-1]) ? (~y + 1) : y;
        hi = 0;
        for (int i = 0; i < W; i++)
            if (m[i]) hi = i + 1;
        return (hi < 1) ? 1 : hi;
`else
        if (sm) return W;
        if (y == '0) return W;
        return W;
`endif
    endfunction

    // Present operands and wait (bounded) for acceptance; returns at accept edge + 1.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sm, output logic ok);
        int g;
        @(negedge clk);
        a = x; b = y; signed_mode = sm; in_valid = 1'b1;
        g = 0;
        while (in_ready !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        ok = (in_ready === 1'b1);
        if (ok) begin
            @(posedge clk);
            exp_q.push_back(model_mul(x, y, sm));
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Count clock edges until out_valid is seen (bounded).
    task automatic wait_result(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
        end while (out_valid !== 1'b1 && cyc < 200);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; signed_mode = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b product=%h, required 1 0 0",
                     in_ready, out_valid, product);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic ok;
        int   lat;
        logic [2*W-1:0] e;
        out_ready = 1'b1;
        issue(32'd3, 32'd5, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_accept: in_ready never high"); end
        wait_result(lat);
        n_checks++;
        if (lat !== exp_lat(32'd5, 1'b0)) begin
            n_fail++; $display("FAIL basic_latency: got %0d cycles, required %0d", lat, exp_lat(32'd5, 1'b0));
        end
        e = exp_q.pop_front();
        n_checks++;
        if (product !== e || product !== 64'h000000000000000F) begin
            n_fail++; $display("FAIL basic_product: got %h, required %h", product, 64'hF);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL basic_inready_done: got %b, required 0", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_return_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_signed();
        logic [W-1:0]   ta[6] = '{32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000007, 32'h80000000};
        logic [W-1:0]   tb[6] = '{32'h00000006, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001};
        logic           ts[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [2*W-1:0] tc[6] = '{64'hFFFFFFFFFFFFFFD6, 64'hFFFFFFFE00000001, 64'h4000000000000000,
                                  64'h0000000000000001, 64'hFFFFFFFFFFFFFFEB, 64'hFFFFFFFF80000000};
        logic ok;
        int   lat;
        logic [2*W-1:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i], ts[i], ok);
            wait_result(lat);
            n_checks++;
            if (!ok || lat !== exp_lat(tb[i], ts[i])) begin
                n_fail++; $display("FAIL signed_latency[%0d]: accepted=%b got %0d cycles, required %0d",
                                   i, ok, lat, exp_lat(tb[i], ts[i]));
            end
            e = exp_q.pop_front();
            n_checks++;
            if (product !== e || product !== tc[i]) begin
                n_fail++; $display("FAIL signed_product[%0d]: got %h, required %h", i, product, tc[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        int   lat;
        logic [2*W-1:0] e;
        out_ready = 1'b0;
        issue(32'h00001111, 32'h00000022, 1'b0, ok);
        wait_result(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || out_valid !== 1'b1 || product !== e) begin
            n_fail++; $display("FAIL bp_result: out_valid=%b product=%h, required 1 %h", out_valid, product, e);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (product !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: product=%h out_valid=%b in_ready=%b, required %h 1 0",
                                   i, product, out_valid, in_ready, e);
            end
            in_valid = ~in_valid;
            a = $urandom;
            b = $urandom;
            signed_mode = ~signed_mode;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== e) begin
            n_fail++; $display("FAIL bp_transfer: out_valid=%b in_ready=%b product=%h, required 0 1 %h",
                               out_valid, in_ready, product, e);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_single_transfer: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset_midop();
        logic ok;
        int   lat;
        logic [2*W-1:0] e;
        out_ready = 1'b1;
        issue(32'h00001234, 32'h0000FFFF, 1'b0, ok);
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        n_checks++;
        if (!ok || out_valid !== 1'b0 || product !== '0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset: out_valid=%b product=%h in_ready=%b, required 0 0 1",
                               out_valid, product, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(32'd2, 32'd9, 1'b0, ok);
        wait_result(lat);
        n_checks++;
        if (!ok || lat !== exp_lat(32'd9, 1'b0)) begin
            n_fail++; $display("FAIL post_reset_latency: got %0d cycles, required %0d", lat, exp_lat(32'd9, 1'b0));
        end
        e = exp_q.pop_front();
        n_checks++;
        if (product !== e || product !== 64'd18) begin
            n_fail++; $display("FAIL post_reset_product: got %h, required %h", product, 64'd18);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta[4] = '{32'd11, 32'hFFFFFFFE, 32'h0000ABCD, 32'h7FFFFFFF};
        logic [W-1:0] tb[4] = '{32'd13, 32'd3, 32'h00001000, 32'hFFFFFFFF};
        logic         ts[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int accepts = 0;
        int got = 0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int g;
                    a = ta[i]; b = tb[i]; signed_mode = ts[i];
                    g = 0;
                    while (in_ready !== 1'b1 && g < 200) begin
                        @(negedge clk);
                        g++;
                    end
                    if (in_ready === 1'b1) begin
                        @(posedge clk);
                        exp_q.push_back(model_mul(ta[i], tb[i], ts[i]));
                        accepts++;
                        #1;
                        if (i == 3) in_valid = 1'b0;
                        @(negedge clk);
                    end
                end
                in_valid = 1'b0;
            end
            begin
                int cyc = 0;
                while (got < 4 && cyc < 400) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid === 1'b1) begin
                        logic [2*W-1:0] e;
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                        n_checks++;
                        if (product !== e || in_ready !== 1'b0) begin
                            n_fail++; $display("FAIL b2b_product[%0d]: got %h in_ready=%b, required %h 0",
                                               got, product, in_ready, e);
                        end
                        got++;
                    end
                end
            end
        join
        n_checks++;
        if (accepts !== 4 || got !== 4 || exp_q.size() !== 0) begin
            n_fail++; $display("FAIL b2b_count: accepts=%0d results=%0d pending=%0d, required 4 4 0",
                               accepts, got, exp_q.size());
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_early_term();
        logic [W-1:0] ta[4] = '{32'h00001234, 32'h0000ABCD, 32'h00000055, 32'h00000003};
        logic [W-1:0] tb[4] = '{32'd5, 32'd0, 32'hFFFFFFFF, 32'h80000000};
        logic         ts[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`ifdef SEQ_MUL_EARLY_TERM_EN
        int           tl[4] = '{3, 1, 1, 32};
`else
        int           tl[4] = '{32, 32, 32, 32};
`endif
        logic [2*W-1:0] tc[4] = '{64'h0000000000005B04, 64'h0, 64'hFFFFFFFFFFFFFFAB, 64'h0000000180000000};
        logic ok;
        int   lat;
        logic [2*W-1:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i], ts[i], ok);
            wait_result(lat);
            n_checks++;
            if (!ok || lat !== tl[i]) begin
                n_fail++; $display("FAIL term_latency[%0d]: accepted=%b got %0d cycles, required %0d", i, ok, lat, tl[i]);
            end
            e = exp_q.pop_front();
            n_checks++;
            if (product !== e || product !== tc[i]) begin
                n_fail++; $display("FAIL term_product[%0d]: got %h, required %h", i, product, tc[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        test_early_term();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
